reg_dump_streamer: RTL and testbench
====================================

Name: reg_dump_streamer

Overview:
- Reader side of the register file's 176-bit debug snapshot bus.
- On a start request, it captures one snapshot of R0..R7, SP, EPC and ESP.
- It then streams the snapshot as a framed byte sequence over a valid/ready byte interface. The UART transmitter consumes this stream for the debug console.
- It sits between the register file debug output and the UART TX path. It never touches the CPU datapath.

Parameters:
- NUM_REGS, 11, number of 16-bit registers on the snapshot bus.
- REG_WIDTH, 16, bits per register; fixed at 16 in this design.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- debug_registers  input  176  snapshot bus; R0 in bits [175:160], down to ESP in bits [15:0].
- start  input  1  request a dump; sampled only in IDLE.
- byte_data  output  8  current frame byte.
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  consumer accepts the byte when byte_valid && byte_ready.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE, byte_valid=0, byte_data=0, busy=0, done=0, index=0, checksum=0.
- Frame format, 24 bytes:
  - HEADER_BYTE.
  - 22 data bytes: R0 high byte, R0 low byte, R1 high byte, ... ESP low byte.
  - Checksum: XOR of the 22 data bytes. The header is excluded from the checksum.
- State IDLE:
  - If start=1: latch debug_registers into a 176-bit shadow register, clear checksum and index, go to HEADER.
  - On the next cycle, byte_valid=1 and byte_data=HEADER_BYTE. Start-to-first-valid latency is 1 cycle.
- State HEADER:
  - Hold the byte until the handshake completes, then go to DATA with index=0.
  - On the next cycle, byte_data = shadow byte 0.
- State DATA:
  - byte_data = shadow byte[index], where byte k = shadow[175-8k -: 8].
  - On handshake: checksum ^= byte_data and index += 1.
  - When the handshake occurs at index=21, go to CHECKSUM. byte_data then equals the final checksum, which includes byte 21.
- State CHECKSUM: on handshake, drop byte_valid and go to DONE.
- State DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Handshake rules:
  - While byte_valid=1 and byte_ready=0, byte_data holds stable and byte_valid stays high.
  - byte_valid never depends combinationally on byte_ready.
  - The block supports back-to-back acceptance: with byte_ready held high, a frame is 24 consecutive valid cycles.
- The shadow is captured once at start. Changes on debug_registers during a dump do not affect the frame.
- start while busy (any state other than IDLE) is ignored with no queuing. start in the DONE cycle is also ignored.
- byte_ready with byte_valid=0 has no effect.
- Reset mid-frame: the next cycle is IDLE with byte_valid=0 and no done pulse. The partial frame is abandoned and the consumer must resync on HEADER_BYTE.
- Index width is 5 bits and never wraps past 21.
- busy is high in HEADER, DATA and CHECKSUM.

Decomposition:
- Shared package, also used by the UART TX and the console decoder:
  - State encoding typedef: IDLE, HEADER, DATA, CHECKSUM, DONE.
  - Constants: HEADER_BYTE, FRAME_BYTES=24, DATA_BYTES=22.
- No sub-module is needed.
- Byte selection from the shadow is done with a shift-left-by-8 of the shadow on each DATA handshake, so the current data byte is always shadow[175:168]. This avoids a wide mux.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset for 2 cycles with start=1.
  - Required: byte_valid=0, busy=0, done=0 throughout. No frame starts until reset is deasserted.
- Single-register dump:
  - Stimulus: R0=16'h1234, all other registers 0, byte_ready held 1, pulse start.
  - Required: bytes A5, 12, 34, then 20 bytes of 00, then checksum 26. That is 24 consecutive valid cycles, with done pulsing on the following cycle.
- Full pattern with backpressure:
  - Stimulus: R_i = {i, i} bytes (R0=0000, R1=0101, ... ESP=0A0A). Toggle byte_ready every other cycle.
  - Required: byte_data is stable during stalls, and the byte order matches the frame format.
  - Required checksum: 00. Each register contributes two equal bytes, which cancel under XOR.
- Snapshot isolation and ignored start:
  - Stimulus: start a dump of R0=16'hBEEF, then change R0 to 16'h0000 and pulse start again mid-frame.
  - Required: the frame still carries BE, EF. Exactly one frame and one done pulse are produced.
- Reset mid-frame:
  - Stimulus: assert reset after the 5th accepted byte.
  - Required: byte_valid=0 on the next cycle and no done pulse.
  - Then pulse start again. Required: a full fresh 24-byte frame beginning with A5.
- Stall on final byte:
  - Stimulus: hold byte_ready=0 for 10 cycles while the checksum byte is presented.
  - Required: busy=1 and the checksum held for all 10 cycles. done pulses 1 cycle after byte_ready rises.

Source files
------------

// File: rtl/reg_dump_streamer_pkg.sv
// rtl/reg_dump_streamer_pkg.sv - shared state encoding and frame constants for the register dump stream
package reg_dump_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    CHECKSUM,
    DONE
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         FRAME_BYTES = 24;
  localparam int         DATA_BYTES  = 22;

endpackage

// File: rtl/reg_dump_streamer.sv
// rtl/reg_dump_streamer.sv - captures the register debug snapshot and streams it as a header/data/checksum byte frame
module reg_dump_streamer #(
  parameter int         NUM_REGS    = 11,
  parameter int         REG_WIDTH   = 16,
  parameter logic [7:0] HEADER_BYTE = reg_dump_streamer_pkg::HEADER_BYTE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REGS*REG_WIDTH-1:0] debug_registers,
  input  logic                          start,
  output logic [7:0]                    byte_data,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          busy,
  output logic                          done
);
  import reg_dump_streamer_pkg::*;

  localparam int         DATA_W   = NUM_REGS * REG_WIDTH;
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS * (REG_WIDTH / 8) - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [7:0]          checksum_q, checksum_d;
  logic [4:0]          index_q, index_d;
  logic                accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      checksum_q <= '0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      checksum_q <= checksum_d;
      index_q    <= index_d;
    end
  end

  // Valid comes only from the registered state, never from byte_ready.
  assign byte_valid = (state_q == HEADER) || (state_q == DATA) || (state_q == CHECKSUM);
  assign busy       = byte_valid;
  assign done       = (state_q == DONE);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    byte_data = 8'h00;
    case (state_q)
      HEADER:   byte_data = HEADER_BYTE;
      DATA:     byte_data = shadow_q[DATA_W-1 -: 8];
      CHECKSUM: byte_data = checksum_q;
      default:  byte_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    checksum_d = checksum_q;
    index_d    = index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d   = debug_registers;
          checksum_d = 8'h00;
          index_d    = 5'd0;
          state_d    = HEADER;
        end
      end
      HEADER: begin
        if (accept) begin
          index_d = 5'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        // Shifting keeps the current byte at the top, so no wide byte mux is needed.
        if (accept) begin
          checksum_d = checksum_q ^ shadow_q[DATA_W-1 -: 8];
          shadow_d   = {shadow_q[DATA_W-9:0], 8'h00};
          if (index_q == LAST_IDX) begin
            state_d = CHECKSUM;
          end else begin
            index_d = index_q + 5'd1;
          end
        end
      end
      CHECKSUM: begin
        if (accept) begin
          state_d = DONE;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb/tb_reg_dump_streamer.sv - scoreboard bench for the register dump streamer
module tb_reg_dump_streamer;

  logic         clock = 1'b0;
  logic         reset;
  logic [175:0] debug_registers;
  logic         start;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         byte_ready;
  logic         busy;
  logic         done;

  logic         toggle_en = 1'b0;
  logic         toggle_r = 1'b0;
  logic         manual_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accepted = 0;
  int valid_cycles = 0;
  int done_cnt = 0;
  int last_acc = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  logic [7:0] exp_q[$];

  reg_dump_streamer dut (
    .clock           (clock),
    .reset           (reset),
    .debug_registers (debug_registers),
    .start           (start),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .busy            (busy),
    .done            (done)
  );

  always #5 clock = ~clock;

  assign byte_ready = toggle_en ? toggle_r : manual_ready;

  initial begin
    forever begin
      @(posedge clock);
      #1 toggle_r = ~toggle_r;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [175:0] regs, output logic [7:0] csum);
    logic [7:0] b;
    csum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 22; k++) begin
      b = regs[175-8*k -: 8];
      csum ^= b;
      exp_q.push_back(b);
    end
    exp_q.push_back(csum);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit drop_start, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
    check("done_seen", done, 1);
    if (drop_start) begin
      @(posedge clock);
      #1 start = 1'b0;
    end
  endtask

  // Monitor: scoreboard pops, stall stability, done timing.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (stall_pend) begin
          check("stall_valid", byte_valid, 1);
          check("stall_hold", byte_data, stall_data);
        end
        stall_pend = byte_valid && !byte_ready;
        stall_data = byte_data;
        if (byte_valid) valid_cycles++;
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
          else check("byte", byte_data, exp_q.pop_front());
          accepted++;
          last_acc = cyc;
        end
        if (done) begin
          done_cnt++;
          check("done_latency", cyc - last_acc, 1);
          check("done_busy", busy, 0);
        end
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [175:0] regs;
    logic [7:0]   csum;
    int           base_acc, base_valid, base_done, n;

    reset = 1'b1;
    start = 1'b1;
    debug_registers = '0;

    // Reset held with start high: nothing may start.
    repeat (2) begin
      @(negedge clock);
      check("rst_valid", byte_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", byte_data, 0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("idle_valid", byte_valid, 0);
    end

    // Single-register dump, ready always high.
    regs = '0;
    regs[175:160] = 16'h1234;
    debug_registers = regs;
    push_frame(regs, csum);
    check("model_csum_1234", csum, 8'h26);
    base_acc = accepted; base_valid = valid_cycles; base_done = done_cnt;
    pulse_start();
    @(negedge clock);
    check("first_valid_latency", byte_valid, 1);
    wait_done(60, 1'b0, n);
    check("single_accepted", accepted - base_acc, 24);
    check("single_valid_cycles", valid_cycles - base_valid, 24);
    check("single_done_cnt", done_cnt - base_done, 1);
    check("single_queue_empty", exp_q.size(), 0);

    // Full pattern with toggling backpressure.
    for (int i = 0; i < 11; i++) regs[175-16*i -: 16] = {8'(i), 8'(i)};
    debug_registers = regs;
    push_frame(regs, csum);
    check("model_csum_pattern", csum, 8'h00);
    base_acc = accepted;
    toggle_en = 1'b1;
    pulse_start();
    wait_done(200, 1'b0, n);
    toggle_en = 1'b0;
    check("pattern_accepted", accepted - base_acc, 24);
    check("pattern_queue_empty", exp_q.size(), 0);

    // Snapshot isolation; start re-asserted mid-frame and held through DONE.
    regs = '0;
    regs[175:160] = 16'hBEEF;
    debug_registers = regs;
    push_frame(regs, csum);
    base_acc = accepted; base_done = done_cnt;
    pulse_start();
    repeat (4) @(posedge clock);
    #1 debug_registers[175:160] = 16'h0000;
    start = 1'b1;
    wait_done(60, 1'b1, n);
    repeat (30) @(negedge clock);
    check("iso_accepted", accepted - base_acc, 24);
    check("iso_done_cnt", done_cnt - base_done, 1);
    check("iso_idle_after", byte_valid, 0);
    check("iso_queue_empty", exp_q.size(), 0);

    // Reset after the 5th accepted byte.
    regs = '0;
    for (int i = 0; i < 11; i++) regs[175-16*i -: 16] = 16'($urandom);
    debug_registers = regs;
    push_frame(regs, csum);
    base_acc = accepted; base_done = done_cnt;
    pulse_start();
    n = 0;
    while (n < 40 && accepted != base_acc + 5) begin
      @(posedge clock);
      #1 n++;
    end
    check("pre_reset_accepted", accepted - base_acc, 5);
    reset = 1'b1;
    manual_ready = 1'b0;
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    check("midrst_valid", byte_valid, 0);
    check("midrst_busy", busy, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    manual_ready = 1'b1;
    repeat (5) @(negedge clock);
    check("midrst_no_done", done_cnt - base_done, 0);
    push_frame(regs, csum);
    base_acc = accepted;
    pulse_start();
    wait_done(60, 1'b0, n);
    check("fresh_accepted", accepted - base_acc, 24);
    check("fresh_queue_empty", exp_q.size(), 0);

    // Stall on the checksum byte.
    for (int i = 0; i < 11; i++) regs[175-16*i -: 16] = 16'($urandom);
    debug_registers = regs;
    push_frame(regs, csum);
    base_acc = accepted;
    pulse_start();
    n = 0;
    while (n < 60 && accepted != base_acc + 23) begin
      @(posedge clock);
      #1 n++;
    end
    manual_ready = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("csum_stall_busy", busy, 1);
      check("csum_stall_valid", byte_valid, 1);
      check("csum_stall_data", byte_data, csum);
    end
    @(posedge clock);
    #1 manual_ready = 1'b1;
    wait_done(10, 1'b0, n);
    check("csum_done_after_ready", n, 2);
    check("csum_accepted", accepted - base_acc, 24);
    check("csum_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
